aria_round_key_gen: RTL

- Round-key generation stage directly downstream of the key-extension stage.
- Captures the final W0..W3 words and streams encryption round keys ek1..ekN, one per handshake, to the round datapath.
- Round-key count N: 13 for 128-bit keys, 15 for 192-bit keys, 17 for 256-bit keys.
- Each key is two W words XORed, one of them rotated, per the ARIA 1.1 key schedule.

---
 rtl/aria_round_key_gen_if.sv | 41 ++++
 rtl/aria_round_key_gen.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/aria_round_key_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : aria_round_key_gen_if
//  Description : Bundle between the ARIA key-extension stage and the round-key
//                generator. The master side (key extension plus round datapath)
//                drives start/key_len/w0..w3/rk_ready. The slave side
//                (the generator) drives busy/rk/rk_idx/rk_valid/done.
//  Signals     : start, key_len[1:0], w0..w3[W_WIDTH-1:0], busy,
//                rk[W_WIDTH-1:0], rk_idx[IDX_WIDTH-1:0], rk_valid,
//                rk_ready, done
//  Revision    : 1.0 - initial release
// ============================================================================
interface aria_round_key_gen_if #(
    parameter int W_WIDTH   = 128,
    parameter int IDX_WIDTH = 5
);
    logic                 start;
    logic [1:0]           key_len;
    logic [W_WIDTH-1:0]   w0;
    logic [W_WIDTH-1:0]   w1;
    logic [W_WIDTH-1:0]   w2;
    logic [W_WIDTH-1:0]   w3;
    logic                 busy;
    logic [W_WIDTH-1:0]   rk;
    logic [IDX_WIDTH-1:0] rk_idx;
    logic                 rk_valid;
    logic                 rk_ready;
    logic                 done;

    modport master (
        output start, key_len, w0, w1, w2, w3, rk_ready,
        input  busy, rk, rk_idx, rk_valid, done
    );

    modport slave (
        input  start, key_len, w0, w1, w2, w3, rk_ready,
        output busy, rk, rk_idx, rk_valid, done
    );
endinterface
`default_nettype wire

// File: rtl/aria_round_key_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : aria_round_key_gen
//  Description : ARIA encryption round-key generator. Captures the final
//                W0..W3 words from key extension and streams ek1..ekN
//                (N = 13/15/17 for 128/192/256-bit keys) one per valid/ready
//                handshake. Each key is one W word XORed with a rotated W word.
//  Ports       : clk, rst (sync, active-high)
//                kif.start/key_len/w0..w3  - capture request (IDLE only)
//                kif.rk/rk_idx/rk_valid    - round-key stream, rk_ready accepts
//                kif.busy                  - generation in progress
//                kif.done                  - one-cycle pulse after last accept
//  Revision    : 1.0 - initial release
// ============================================================================
module aria_round_key_gen #(
    parameter int W_WIDTH   = 128,
    parameter int IDX_WIDTH = 5
) (
    input  wire logic           clk,
    input  wire logic           rst,
    aria_round_key_gen_if.slave kif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [W_WIDTH-1:0]   r_w0;
    logic [W_WIDTH-1:0]   r_w1;
    logic [W_WIDTH-1:0]   r_w2;
    logic [W_WIDTH-1:0]   r_w3;
    logic [IDX_WIDTH-1:0] r_last;

    logic [W_WIDTH-1:0]   w_first_rk;
    logic [W_WIDTH-1:0]   w_next_rk;
    logic [IDX_WIDTH-1:0] w_len_last;

    // Rotate right by a fixed amount; left rotations are expressed as
    // right rotations by (W_WIDTH - n).
    function automatic logic [W_WIDTH-1:0] ror(
        input logic [W_WIDTH-1:0] x,
        input int unsigned        amt
    );
        return (x >> amt) | (x << (W_WIDTH - amt));
    endfunction

    // Round key for 0-based index i: low two bits choose the word pair,
    // upper bits choose the rotation group.
    function automatic logic [W_WIDTH-1:0] round_key(
        input logic [W_WIDTH-1:0]   a0,
        input logic [W_WIDTH-1:0]   a1,
        input logic [W_WIDTH-1:0]   a2,
        input logic [W_WIDTH-1:0]   a3,
        input logic [IDX_WIDTH-1:0] i
    );
        logic [W_WIDTH-1:0] w_src;
        logic [W_WIDTH-1:0] w_plain;
        logic [W_WIDTH-1:0] w_rot;
        case (i[1:0])
            2'd0:    begin w_src = a1; w_plain = a0; end
            2'd1:    begin w_src = a2; w_plain = a1; end
            2'd2:    begin w_src = a3; w_plain = a2; end
            default: begin w_src = a0; w_plain = a3; end
        endcase
        case (int'(i[IDX_WIDTH-1:2]))
            0:       w_rot = ror(w_src, 19);
            1:       w_rot = ror(w_src, 31);
            2:       w_rot = ror(w_src, W_WIDTH - 61);
            3:       w_rot = ror(w_src, W_WIDTH - 31);
            default: w_rot = ror(w_src, W_WIDTH - 19);
        endcase
        return w_rot ^ w_plain;
    endfunction

    always_comb begin
        // ek1 comes straight from the live inputs so it is ready the cycle
        // after start; later keys use the captured words.
        w_first_rk = round_key(kif.w0, kif.w1, kif.w2, kif.w3, '0);
        // The current 1-based index equals the 0-based index of the next key.
        w_next_rk  = round_key(r_w0, r_w1, r_w2, r_w3, kif.rk_idx);
        case (kif.key_len)
            2'd0:    w_len_last = IDX_WIDTH'(13);
            2'd1:    w_len_last = IDX_WIDTH'(15);
            default: w_len_last = IDX_WIDTH'(17);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_w0         <= '0;
            r_w1         <= '0;
            r_w2         <= '0;
            r_w3         <= '0;
            r_last       <= '0;
            kif.rk       <= '0;
            kif.rk_idx   <= '0;
            kif.rk_valid <= 1'b0;
            kif.busy     <= 1'b0;
            kif.done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    kif.done <= 1'b0;
                    if (kif.start) begin
                        r_w0         <= kif.w0;
                        r_w1         <= kif.w1;
                        r_w2         <= kif.w2;
                        r_w3         <= kif.w3;
                        r_last       <= w_len_last;
                        kif.rk       <= w_first_rk;
                        kif.rk_idx   <= IDX_WIDTH'(1);
                        kif.rk_valid <= 1'b1;
                        kif.busy     <= 1'b1;
                        r_state      <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    if (kif.rk_valid && kif.rk_ready) begin
                        if (kif.rk_idx < r_last) begin
                            kif.rk     <= w_next_rk;
                            kif.rk_idx <= kif.rk_idx + IDX_WIDTH'(1);
                        end else begin
                            // Last key taken: rk/rk_idx keep their values.
                            kif.rk_valid <= 1'b0;
                            kif.busy     <= 1'b0;
                            kif.done     <= 1'b1;
                            r_state      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    kif.done <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
